fetch_ctrl: RTL and testbench
=============================

# fetch_ctrl

Instruction-fetch sequencer for the NPC core. It owns the architectural fetch PC and issues one request at a time on the instruction-memory handshake. It captures the returned instruction and presents it as a valid/ready beat to the fetch→decode pipeline buffer. Redirects from execute are handled by killing stale in-flight responses, and fetch can be paused via `fetch_en`.

## Interface
- `RESET_ADDR`, default `` `CPU_RESET_ADDR `` (32'h8000_0000): PC after reset.
- `NOP_INST`, default `` `INST_NOP `` (32'h0000_0013): `o_inst` reset value.
- `clk`  in  1  clock; all state updates on posedge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `fetch_en`  in  1  1 = fetch allowed; 0 = finish current transaction, then idle.
- `redirect_valid`  in  1  single-cycle PC redirect (branch/jump/trap).
- `redirect_pc`  in  32  redirect target; bits [1:0] ignored (forced 0).
- `imem_req_valid`  out  1  request offered.
- `imem_req_ready`  in  1  memory accepts request.
- `imem_req_addr`  out  32  fetch address, stable while `imem_req_valid` && !`imem_req_ready`.
- `imem_resp_valid`  in  1  response data valid.
- `imem_resp_ready`  out  1  1 only in WAIT.
- `imem_resp_data`  in  32  instruction word.
- `o_valid`  out  1  instruction beat valid (to fetch→decode buffer `i_valid`).
- `o_ready`  in  1  buffer ready (its `i_ready`).
- `o_pc`  out  32  PC of presented instruction.
- `o_inst`  out  32  presented instruction.
- `perf_fetch_cnt`  out  32  count of `o_valid && o_ready` beats; wraps.
- `perf_kill_cnt`  out  32  count of discarded (killed) responses; wraps.

## Operation
- State register (Moore outputs): IDLE, REQ, WAIT, HOLD. `imem_req_valid` = (state==REQ); `imem_resp_ready` = (state==WAIT); `o_valid` = (state==HOLD).
- Internal regs: `pc` (32), `kill` (1), `o_pc`/`o_inst` capture regs, two counters.
- IDLE: `fetch_en`=1 → REQ. Otherwise stay.
- REQ: `imem_req_addr` = `pc`. Request handshake → WAIT. No handshake → stay; the address must not change even if a redirect arrives.
- WAIT: on `imem_resp_valid`:
  - `kill`=1 → clear `kill`, increment `perf_kill_cnt`, go REQ (or IDLE if `fetch_en`=0).
  - `kill`=0 → latch `o_pc`=`pc`, `o_inst`=`imem_resp_data`, go HOLD.
- HOLD: `o_pc`/`o_inst` held stable. On `o_ready`: increment `perf_fetch_cnt`, `pc`←`pc`+4 (mod 2^32), go REQ (IDLE if `fetch_en`=0).
- Redirect (any state) sets `pc`←{`redirect_pc`[31:2],2'b00}. Per-state effects:
  - IDLE: `pc` only.
  - REQ without handshake: `kill`←1, because the old-address request stays pending and is still issued.
  - REQ with handshake same cycle: `kill`←1, go WAIT.
  - WAIT without response: `kill`←1.
  - WAIT with response same cycle: response dropped and counted as killed; go REQ.
  - HOLD: drop the held beat and go REQ. If `o_ready`=1 the same cycle, the beat counts in `perf_fetch_cnt`; downstream flush is the redirector's responsibility, and `pc` takes `redirect_pc`, not +4.
- Redirect has priority over the +4 increment. Only one request may be in flight; `kill` is one bit.
- `fetch_en`=0 never aborts REQ/WAIT/HOLD; it only blocks leaving IDLE and forces the IDLE exit from WAIT(killed) or HOLD.

## Timing
- Reset: state IDLE, `pc`=`RESET_ADDR`, `kill`=0, `o_pc`=`RESET_ADDR`, `o_inst`=`NOP_INST`, counters 0. Outputs: `imem_req_valid`=0, `imem_resp_ready`=0, `o_valid`=0.
- First cycle with `rst_n`=1 and `fetch_en`=1 is IDLE; `imem_req_valid` rises the next cycle.
- Zero-wait memory (ready same cycle, response one cycle later) with `o_ready`=1 gives 3 cycles per instruction: REQ, WAIT, HOLD.
- `o_valid` rises the cycle after the accepted response. It falls the cycle after the `o_ready` handshake or after a redirect.
- Reset asserted mid-transaction forces the reset state next edge. The memory side must also be reset; no response tracking survives reset.

## Structure
- State enum (`fetch_state_e`) goes in the shared core package alongside existing defines. `RESET_ADDR`/`NOP_INST` come from `` `CPU_RESET_ADDR ``/`` `INST_NOP ``.
- Single module; no sub-module required. The two wrap counters may use a shared `perf_counter` primitive if one exists.

## Test plan
- Reset release, `fetch_en`=1, zero-wait memory returning 0x00100093 → `imem_req_addr`=0x8000_0000; `o_valid` in cycle 3 with `o_pc`=0x8000_0000, `o_inst`=0x00100093; next request at 0x8000_0004.
- `o_ready` held 0 for 5 cycles in HOLD → `o_valid`, `o_pc`, `o_inst` stable; no new `imem_req_valid`; `perf_fetch_cnt` unchanged until the handshake.
- Redirect to 0x8000_0100 during WAIT, response 2 cycles later → response dropped, `perf_kill_cnt`=1, next `imem_req_addr`=0x8000_0100, no `o_valid` for the stale word.
- Redirect while REQ is stalled (`imem_req_ready`=0 for 3 cycles) → address stays at the old PC until accepted; that response is killed; the following request uses the redirect target.
- Redirect coinciding with `o_ready` in HOLD → `perf_fetch_cnt`+1, next request at the redirect target, not `pc`+4.
- `fetch_en` dropped in WAIT → instruction delivered in HOLD, then IDLE with no further requests; re-enable → request at `pc`+4.

Source files
------------

// File: rtl/fetch_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// fetch_ctrl_pkg
//
// Purpose: shared core definitions used by the instruction-fetch sequencer.
//   - CPU_RESET_ADDR / INST_NOP defaults (guarded, so an existing core-wide
//     definition takes precedence)
//   - fetch_state_e : fetch sequencer state encoding
//   - PC_STEP       : sequential fetch increment (one 32-bit instruction)
//   - align_pc()    : forces a word-aligned PC
//
// Ports: none (package).
// -----------------------------------------------------------------------------
`ifndef CPU_RESET_ADDR
`define CPU_RESET_ADDR 32'h8000_0000
`endif

`ifndef INST_NOP
`define INST_NOP 32'h0000_0013
`endif

package fetch_ctrl_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] PC_STEP = 32'd4;

    // IDLE: not fetching
    // REQ : request offered on the imem request channel
    // WAIT: request accepted, waiting for the response
    // HOLD: captured instruction presented downstream
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } fetch_state_e;

    // Instructions are 32-bit aligned; the two LSBs of any target are dropped.
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_ctrl_perf_counter.sv
// -----------------------------------------------------------------------------
// fetch_ctrl_perf_counter
//
// Purpose: free-running event counter that wraps modulo 2^WIDTH.
//
// Ports:
//   clk    in   clock
//   rst_n  in   synchronous active-low reset, clears the count
//   inc    in   count one event this cycle
//   count  out  current count
// -----------------------------------------------------------------------------
module fetch_ctrl_perf_counter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_ctrl
//
// Purpose: instruction-fetch sequencer. Owns the architectural fetch PC,
// issues one instruction-memory request at a time, captures the returned
// word and presents it as a valid/ready beat to the fetch->decode buffer.
// Redirects kill any stale in-flight response; fetch_en pauses fetching
// once the current transaction has completed.
//
// Ports:
//   clk              in   clock, all state updates on posedge
//   rst_n            in   synchronous active-low reset
//   fetch_en         in   1 = fetching allowed
//   redirect_valid   in   single-cycle PC redirect
//   redirect_pc      in   redirect target (bits [1:0] ignored)
//   imem_req_valid   out  request offered (state REQ)
//   imem_req_ready   in   memory accepts request
//   imem_req_addr    out  fetch address, stable while the request is pending
//   imem_resp_valid  in   response valid
//   imem_resp_ready  out  response accepted (state WAIT)
//   imem_resp_data   in   instruction word
//   o_valid          out  instruction beat valid (state HOLD)
//   o_ready          in   downstream buffer ready
//   o_pc             out  PC of presented instruction
//   o_inst           out  presented instruction
//   perf_fetch_cnt   out  delivered beats, wraps
//   perf_kill_cnt    out  discarded responses, wraps
// -----------------------------------------------------------------------------
`ifndef CPU_RESET_ADDR
`define CPU_RESET_ADDR 32'h8000_0000
`endif

`ifndef INST_NOP
`define INST_NOP 32'h0000_0013
`endif

module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_ADDR = `CPU_RESET_ADDR,
    parameter logic [31:0] NOP_INST   = `INST_NOP
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_en,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    output logic        imem_resp_ready,
    input  logic [31:0] imem_resp_data,
    output logic        o_valid,
    input  logic        o_ready,
    output logic [31:0] o_pc,
    output logic [31:0] o_inst,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_kill_cnt
);

    fetch_state_e state;

    logic [31:0] pc;
    logic [31:0] pc_next;
    logic [31:0] req_addr;
    logic [31:0] redirect_target;
    logic        kill;

    logic        req_fire;
    logic        resp_fire;
    logic        beat_fire;
    logic        drop_resp;

    logic        unused_redirect_lsbs;

    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    assign redirect_target = align_pc(redirect_pc);

    assign req_fire  = (state == REQ)  && imem_req_ready;
    assign resp_fire = (state == WAIT) && imem_resp_valid;
    assign beat_fire = (state == HOLD) && o_ready;

    // A response is discarded when it belongs to a request issued before a
    // redirect, including a redirect arriving in the same cycle as the data.
    assign drop_resp = resp_fire && (kill || redirect_valid);

    // Redirect wins over the sequential +4 step.
    always_comb begin
        pc_next = pc;
        if (redirect_valid) begin
            pc_next = redirect_target;
        end else if (beat_fire) begin
            pc_next = pc + PC_STEP;
        end
    end

    // Moore outputs decoded straight from the state register.
    assign imem_req_valid  = (state == REQ);
    assign imem_resp_ready = (state == WAIT);
    assign o_valid         = (state == HOLD);
    assign imem_req_addr   = req_addr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            pc       <= RESET_ADDR;
            req_addr <= RESET_ADDR;
            kill     <= 1'b0;
            o_pc     <= RESET_ADDR;
            o_inst   <= NOP_INST;
        end else begin
            pc <= pc_next;

            // The offered address is frozen for the whole REQ phase so a
            // redirect cannot change a request the memory may be sampling.
            // Outside REQ it tracks the PC the next request will use.
            if (state != REQ) begin
                req_addr <= pc_next;
            end

            case (state)
                IDLE: begin
                    if (fetch_en) begin
                        state <= REQ;
                    end
                end

                REQ: begin
                    // The pending old-address request still completes, so
                    // its response must be thrown away.
                    if (redirect_valid) begin
                        kill <= 1'b1;
                    end
                    if (req_fire) begin
                        state <= WAIT;
                    end
                end

                WAIT: begin
                    if (resp_fire) begin
                        if (drop_resp) begin
                            kill  <= 1'b0;
                            state <= fetch_en ? REQ : IDLE;
                        end else begin
                            o_pc   <= pc;
                            o_inst <= imem_resp_data;
                            state  <= HOLD;
                        end
                    end else if (redirect_valid) begin
                        kill <= 1'b1;
                    end
                end

                HOLD: begin
                    if (redirect_valid || o_ready) begin
                        state <= fetch_en ? REQ : IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    fetch_ctrl_perf_counter #(
        .WIDTH (32)
    ) u_fetch_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (beat_fire),
        .count (perf_fetch_cnt)
    );

    fetch_ctrl_perf_counter #(
        .WIDTH (32)
    ) u_kill_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (drop_resp),
        .count (perf_kill_cnt)
    );

endmodule

// File: tb/tb_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fetch_ctrl
//
// Directed bench for fetch_ctrl. Inputs are changed 1 time unit after each
// rising edge and outputs are sampled at the same point, so every value seen
// reflects the state after the preceding edge.
// -----------------------------------------------------------------------------
module tb_fetch_ctrl;

    logic        clk;
    logic        rst_n;
    logic        fetch_en;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic        imem_resp_ready;
    logic [31:0] imem_resp_data;
    logic        o_valid;
    logic        o_ready;
    logic [31:0] o_pc;
    logic [31:0] o_inst;
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_kill_cnt;

    int passed;
    int total;

    fetch_ctrl dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .fetch_en        (fetch_en),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_ready (imem_resp_ready),
        .imem_resp_data  (imem_resp_data),
        .o_valid         (o_valid),
        .o_ready         (o_ready),
        .o_pc            (o_pc),
        .o_inst          (o_inst),
        .perf_fetch_cnt  (perf_fetch_cnt),
        .perf_kill_cnt   (perf_kill_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n           = 1'b0;
        fetch_en        = 1'b0;
        redirect_valid  = 1'b0;
        redirect_pc     = 32'h0;
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;
        o_ready         = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // flags = {imem_req_valid, imem_resp_ready, o_valid}
    task automatic test_reset();
        do_reset();
        total++;
        if ({imem_req_valid, imem_resp_ready, o_valid} !== 3'b000)
            $display("FAIL reset_flags got %b exp %b", {imem_req_valid, imem_resp_ready, o_valid}, 3'b000);
        else passed++;
        total++;
        if (o_pc !== 32'h8000_0000) $display("FAIL reset_o_pc got %h exp %h", o_pc, 32'h8000_0000);
        else passed++;
        total++;
        if (o_inst !== 32'h0000_0013) $display("FAIL reset_o_inst got %h exp %h", o_inst, 32'h0000_0013);
        else passed++;
        total++;
        if ({perf_fetch_cnt, perf_kill_cnt} !== 64'h0)
            $display("FAIL reset_counters got %h/%h exp 0/0", perf_fetch_cnt, perf_kill_cnt);
        else passed++;
        // fetch_en low: stay idle
        tick();
        tick();
        total++;
        if (imem_req_valid !== 1'b0) $display("FAIL idle_no_req got %b exp 0", imem_req_valid);
        else passed++;
    endtask

    task automatic test_back_to_back();
        do_reset();
        fetch_en       = 1'b1;
        imem_req_ready = 1'b1;
        o_ready        = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            total++;
            if ({imem_req_valid, imem_resp_ready, o_valid} !== 3'b100 || imem_req_addr !== 32'h8000_0000 + 32'(i * 4))
                $display("FAIL b2b_req%0d got flags %b addr %h exp 100 %h", i,
                         {imem_req_valid, imem_resp_ready, o_valid}, imem_req_addr, 32'h8000_0000 + 32'(i * 4));
            else passed++;
            tick();
            total++;
            if ({imem_req_valid, imem_resp_ready, o_valid} !== 3'b010)
                $display("FAIL b2b_wait%0d got %b exp 010", i, {imem_req_valid, imem_resp_ready, o_valid});
            else passed++;
            imem_resp_valid = 1'b1;
            imem_resp_data  = 32'h0010_0093 + 32'(i << 20);
            tick();
            imem_resp_valid = 1'b0;
            total++;
            if (o_valid !== 1'b1 || o_pc !== 32'h8000_0000 + 32'(i * 4) || o_inst !== 32'h0010_0093 + 32'(i << 20))
                $display("FAIL b2b_hold%0d got v=%b pc=%h inst=%h exp v=1 pc=%h inst=%h", i, o_valid, o_pc, o_inst,
                         32'h8000_0000 + 32'(i * 4), 32'h0010_0093 + 32'(i << 20));
            else passed++;
            tick();
        end
        total++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_000C || perf_fetch_cnt !== 32'd3)
            $display("FAIL b2b_after got req=%b addr=%h cnt=%0d exp 1 8000000c 3", imem_req_valid, imem_req_addr, perf_fetch_cnt);
        else passed++;
    endtask

    task automatic test_hold_stall();
        do_reset();
        fetch_en       = 1'b1;
        tick();
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'h0020_0113;
        tick();
        imem_resp_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            total++;
            if ({imem_req_valid, o_valid} !== 2'b01 || o_pc !== 32'h8000_0000 || o_inst !== 32'h0020_0113 || perf_fetch_cnt !== 32'd0)
                $display("FAIL hold_stable%0d got req=%b v=%b pc=%h inst=%h cnt=%0d exp 0 1 80000000 00200113 0",
                         i, imem_req_valid, o_valid, o_pc, o_inst, perf_fetch_cnt);
            else passed++;
            tick();
        end
        o_ready = 1'b1;
        tick();
        total++;
        if ({imem_req_valid, o_valid} !== 2'b10 || imem_req_addr !== 32'h8000_0004 || perf_fetch_cnt !== 32'd1)
            $display("FAIL hold_release got req=%b v=%b addr=%h cnt=%0d exp 1 0 80000004 1",
                     imem_req_valid, o_valid, imem_req_addr, perf_fetch_cnt);
        else passed++;
    endtask

    task automatic test_redirect_wait();
        do_reset();
        fetch_en = 1'b1;
        tick();
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0103;
        tick();
        redirect_valid = 1'b0;
        total++;
        if ({imem_resp_ready, o_valid} !== 2'b10)
            $display("FAIL rdw_wait got %b exp 10", {imem_resp_ready, o_valid});
        else passed++;
        tick();
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'hDEAD_BEEF;
        tick();
        imem_resp_valid = 1'b0;
        total++;
        if ({imem_req_valid, imem_resp_ready, o_valid} !== 3'b100 || imem_req_addr !== 32'h8000_0100)
            $display("FAIL rdw_next got flags %b addr %h exp 100 80000100",
                     {imem_req_valid, imem_resp_ready, o_valid}, imem_req_addr);
        else passed++;
        total++;
        if (perf_kill_cnt !== 32'd1 || perf_fetch_cnt !== 32'd0)
            $display("FAIL rdw_counts got kill=%0d fetch=%0d exp 1 0", perf_kill_cnt, perf_fetch_cnt);
        else passed++;
    endtask

    task automatic test_redirect_req_stall();
        do_reset();
        fetch_en       = 1'b1;
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0200;
        tick();
        redirect_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            total++;
            if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0000)
                $display("FAIL rdr_stall%0d got req=%b addr=%h exp 1 80000000", i, imem_req_valid, imem_req_addr);
            else passed++;
            if (i < 2) tick();
        end
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'h0030_0193;
        tick();
        imem_resp_valid = 1'b0;
        total++;
        if ({imem_req_valid, o_valid} !== 2'b10 || imem_req_addr !== 32'h8000_0200 || perf_kill_cnt !== 32'd1)
            $display("FAIL rdr_after got req=%b v=%b addr=%h kill=%0d exp 1 0 80000200 1",
                     imem_req_valid, o_valid, imem_req_addr, perf_kill_cnt);
        else passed++;
    endtask

    task automatic test_redirect_hold();
        do_reset();
        fetch_en = 1'b1;
        tick();
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'h0040_0213;
        tick();
        imem_resp_valid = 1'b0;
        o_ready         = 1'b1;
        redirect_valid  = 1'b1;
        redirect_pc     = 32'h8000_0300;
        tick();
        redirect_valid = 1'b0;
        total++;
        if ({imem_req_valid, o_valid} !== 2'b10 || imem_req_addr !== 32'h8000_0300 || perf_fetch_cnt !== 32'd1)
            $display("FAIL rdh_next got req=%b v=%b addr=%h cnt=%0d exp 1 0 80000300 1",
                     imem_req_valid, o_valid, imem_req_addr, perf_fetch_cnt);
        else passed++;
    endtask

    task automatic test_fetch_en_drop();
        do_reset();
        fetch_en = 1'b1;
        tick();
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        fetch_en       = 1'b0;
        tick();
        total++;
        if (imem_resp_ready !== 1'b1) $display("FAIL fen_wait got %b exp 1", imem_resp_ready);
        else passed++;
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'h0050_0293;
        tick();
        imem_resp_valid = 1'b0;
        total++;
        if (o_valid !== 1'b1 || o_inst !== 32'h0050_0293)
            $display("FAIL fen_hold got v=%b inst=%h exp 1 00500293", o_valid, o_inst);
        else passed++;
        o_ready = 1'b1;
        tick();
        tick();
        tick();
        total++;
        if ({imem_req_valid, imem_resp_ready, o_valid} !== 3'b000 || perf_fetch_cnt !== 32'd1)
            $display("FAIL fen_idle got flags %b cnt %0d exp 000 1", {imem_req_valid, imem_resp_ready, o_valid}, perf_fetch_cnt);
        else passed++;
        fetch_en = 1'b1;
        tick();
        total++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0004)
            $display("FAIL fen_resume got req=%b addr=%h exp 1 80000004", imem_req_valid, imem_req_addr);
        else passed++;
    endtask

    task automatic test_wrap_and_midreset();
        do_reset();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFF;
        tick();
        redirect_valid = 1'b0;
        fetch_en       = 1'b1;
        tick();
        total++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'hFFFF_FFFC)
            $display("FAIL wrap_req got req=%b addr=%h exp 1 fffffffc", imem_req_valid, imem_req_addr);
        else passed++;
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'h0060_0313;
        tick();
        imem_resp_valid = 1'b0;
        total++;
        if (o_pc !== 32'hFFFF_FFFC) $display("FAIL wrap_o_pc got %h exp fffffffc", o_pc);
        else passed++;
        o_ready = 1'b1;
        tick();
        total++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0000_0000)
            $display("FAIL wrap_next got req=%b addr=%h exp 1 00000000", imem_req_valid, imem_req_addr);
        else passed++;
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        rst_n          = 1'b0;
        tick();
        total++;
        if ({imem_req_valid, imem_resp_ready, o_valid} !== 3'b000 || perf_fetch_cnt !== 32'd0 ||
            o_pc !== 32'h8000_0000 || o_inst !== 32'h0000_0013)
            $display("FAIL midreset got flags %b cnt %0d pc %h inst %h exp 000 0 80000000 00000013",
                     {imem_req_valid, imem_resp_ready, o_valid}, perf_fetch_cnt, o_pc, o_inst);
        else passed++;
        rst_n = 1'b1;
        tick();
        total++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0000)
            $display("FAIL midreset_restart got req=%b addr=%h exp 1 80000000", imem_req_valid, imem_req_addr);
        else passed++;
    endtask

    initial begin
        passed = 0;
        total  = 0;
        test_reset();
        test_back_to_back();
        test_hold_stall();
        test_redirect_wait();
        test_redirect_req_stall();
        test_redirect_hold();
        test_fetch_en_drop();
        test_wrap_and_midreset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
